deparse_action_sched: RTL
=========================

# deparse_action_sched

Sequencer that drives the shared `sub_deparser` lane for the deparser's header-reform step. It accepts one packet's PHV container block and its parse-action list, then loads the PHV into the sub-deparser. It issues the actions one per cycle and turns each sub-deparser result into a byte-offset write command for the header rewrite buffer. It sits between the deparser's packet-header FIFO/BRAM lookup and the header rewrite logic.

## Interface
- C_PHV_WIDTH, 768, container block width (8×2B, 8×4B, 8×6B; 2B at bit 0, 4B at bit 128, 6B at bit 384).
- C_NUM_ACTIONS, 10, parse-action slots per packet.
- C_ACTION_WIDTH, 16, bits per action: [0] valid, [3:1] container index, [5:4] type (01=2B, 10=4B, 11=6B), [12:6] byte offset, [15:13] reserved.
- C_OFFSET_WIDTH, 7, byte-offset width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_phv  in  C_PHV_WIDTH  containers for the packet.
- in_actions  in  C_NUM_ACTIONS*C_ACTION_WIDTH  slot 0 in the MSBs.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- sd_phv  out  C_PHV_WIDTH  to sub_deparser deparse_phv_reg_in.
- sd_phv_valid  out  1  to deparse_phv_reg_valid_in.
- sd_action  out  6  to parse_action (action bits [5:0]).
- sd_action_valid  out  1  to parse_action_valid_in.
- sd_data  in  48  from deparse_phv_reg_out.
- sd_select  in  2  from deparse_phv_select.
- sd_valid  in  1  from valid_out.
- wr_data  out  48  field value, right-aligned.
- wr_offset  out  C_OFFSET_WIDTH  destination byte offset.
- wr_len  out  2  01=2B, 10=4B, 11=6B.
- wr_valid  out  1  write command strobe.
- done  out  1  one-cycle pulse when the packet is finished.
- rsp_err  out  1  one-cycle pulse: sd_valid with no outstanding issue, or sd_select ≠ issued type.

## Operation
- States: IDLE → LOAD → ISSUE → DRAIN → DONE → IDLE.
- IDLE: in_ready=1. On in_valid, capture in_phv and in_actions into registers, clear slot counter, and go to LOAD.
- LOAD (1 cycle): sd_phv is the captured PHV and sd_phv_valid=1. This guarantees the sub-deparser holds the PHV before the first action is sampled.
- ISSUE: one slot per cycle, slot counter 0..C_NUM_ACTIONS-1.
  - A slot is issuable if bit0=1 and type≠00.
  - Issuable slot: sd_action=slot[5:0] and sd_action_valid=1. Push {offset, type} into a 2-entry expectation pipe.
  - Non-issuable slot: sd_action_valid=0. The cycle is still consumed.
  - After the last slot, go to DRAIN.
- Response handling: on sd_valid, pop the expectation pipe and register wr_data=sd_data masked to the type width (upper bits zero), wr_offset, wr_len, wr_valid=1.
  - If the pipe is empty, no write occurs and rsp_err pulses.
  - If sd_select mismatches the issued type, the write is still issued with the expected type and rsp_err pulses.
- DRAIN: exactly 2 cycles, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Offsets pass through unmodified; no range check.
- Reset, including mid-packet: state IDLE, expectation pipe cleared, all outputs 0 except in_ready=1 once in IDLE (the cycle after rst deasserts). Captured registers zeroed.

## Timing
- Capture edge = cycle T.
- LOAD at T+1; slot k issued at T+2+k.
- Sub-deparser result at T+3+k; wr_valid for slot k at T+4+k.
- Default build: DRAIN at T+2+N and T+3+N; done at T+N+4; in_ready high again at T+N+5. Here N=C_NUM_ACTIONS.
- Back-to-back packets: a new capture occurs at the earliest at T+N+5. Throughput is one packet per N+5 cycles.
- wr_valid is never asserted in IDLE or LOAD.
- At most 2 expectations are outstanding.

## Configuration
- DEPARSE_SCHED_EARLY_EXIT_EN defined: the first slot with bit0=0 ends ISSUE; that cycle goes directly to DRAIN and the remaining slots are ignored.
  - With slot m as the first invalid slot, done is at T+m+4.
  - Slots with bit0=1 and type=00 are still skipped without terminating.
- Not defined: all C_NUM_ACTIONS slots are always scanned, and done is at T+N+4 regardless of contents.

## Test plan
- Single 2B action: slot0=idx 3, type 01, offset 12; other slots 0; PHV 2B container 3=16'hBEEF → at T+4, one wr: data 48'h00000000BEEF, offset 12, len 01. done at T+14 (T+5 with EARLY_EXIT_EN).
- Mixed 2B/4B/6B: slots 0..2 = 6B idx7 off0, 4B idx0 off6, 2B idx5 off10 → wr at T+4, T+5, T+6 with the matching containers and offsets in slot order. No rsp_err.
- Gaps: slots 1 and 4 valid, slot 2 valid with type 00 → exactly 2 writes, at T+5 and T+8. Slot 2 issues nothing.
- Back-to-back: in_valid held high with two packets → second capture exactly at T+15 (N=10). No overlap of wr streams.
- Reset during ISSUE at slot 3 → next cycle all outputs 0. Later sd_valid from in-flight actions raises rsp_err only, with no wr. A fresh packet after reset completes normally.
- Spurious response: sd_valid forced in IDLE → rsp_err pulse, wr_valid stays 0.

Source files
------------

// File: rtl/deparse_action_sched.sv
// Sequencer for the shared sub_deparser lane: loads one packet's PHV, issues its parse actions
// one per cycle and turns each result into a rewrite-buffer write. Option: DEPARSE_SCHED_EARLY_EXIT_EN.
module deparse_action_sched #(
   parameter int unsigned C_PHV_WIDTH    = 768,
   parameter int unsigned C_NUM_ACTIONS  = 10,
   parameter int unsigned C_ACTION_WIDTH = 16,
   parameter int unsigned C_OFFSET_WIDTH = 7
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [C_PHV_WIDTH-1:0]                   in_phv,
   input  logic [C_NUM_ACTIONS*C_ACTION_WIDTH-1:0]  in_actions,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic [C_PHV_WIDTH-1:0]                   sd_phv,
   output logic                                     sd_phv_valid,
   output logic [5:0]                               sd_action,
   output logic                                     sd_action_valid,
   input  logic [47:0]                              sd_data,
   input  logic [1:0]                               sd_select,
   input  logic                                     sd_valid,
   output logic [47:0]                              wr_data,
   output logic [C_OFFSET_WIDTH-1:0]                wr_offset,
   output logic [1:0]                               wr_len,
   output logic                                     wr_valid,
   output logic                                     done,
   output logic                                     rsp_err
);

   localparam int unsigned CW = (C_NUM_ACTIONS > 1) ? $clog2(C_NUM_ACTIONS) : 1;
   localparam int unsigned EW = C_OFFSET_WIDTH + 2;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                                 state_q, state_d;
   logic [CW-1:0]                          slot_q, slot_d;
   logic                                   drain_q, drain_d;
   logic [C_PHV_WIDTH-1:0]                 phv_q;
   logic [C_NUM_ACTIONS*C_ACTION_WIDTH-1:0] actions_q;
   logic [EW-1:0]                          exp_q [2];
   logic [EW-1:0]                          exp_d [2];
   logic [1:0]                             cnt_q, cnt_d;
   logic [47:0]                            wr_data_q;
   logic [C_OFFSET_WIDTH-1:0]              wr_offset_q;
   logic [1:0]                             wr_len_q;
   logic                                   wr_valid_q;
   logic                                   rsp_err_q;

   logic                                   capture;
   logic                                   push;
   logic                                   pop;
   logic [C_ACTION_WIDTH-1:0]              slot_w [C_NUM_ACTIONS];
   logic [C_ACTION_WIDTH-1:0]              cur;
   logic [EW-1:0]                          head;
   logic [C_NUM_ACTIONS-1:0]               unused_rsv;

   // Slot 0 lives in the MSBs of the action vector.
   for (genvar k = 0; k < C_NUM_ACTIONS; k++) begin : g_slot
      assign slot_w[k]     = actions_q[(C_NUM_ACTIONS-1-k)*C_ACTION_WIDTH +: C_ACTION_WIDTH];
      assign unused_rsv[k] = ^slot_w[k][C_ACTION_WIDTH-1:13];
   end

   assign cur  = slot_w[slot_q];
   assign head = exp_q[0];

   function automatic logic issuable(input logic [C_ACTION_WIDTH-1:0] a);
      issuable = a[0] && (a[5:4] != 2'b00);
   endfunction

   function automatic logic [47:0] mask_field(input logic [47:0] d, input logic [1:0] t);
      case (t)
         2'b01:   mask_field = {32'd0, d[15:0]};
         2'b10:   mask_field = {16'd0, d[31:0]};
         2'b11:   mask_field = d;
         default: mask_field = '0;
      endcase
   endfunction

   always_comb begin
      state_d         = state_q;
      slot_d          = slot_q;
      drain_d         = 1'b0;
      capture         = 1'b0;
      push            = 1'b0;
      sd_phv_valid    = 1'b0;
      sd_action       = '0;
      sd_action_valid = 1'b0;
      done            = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               capture = 1'b1;
               slot_d  = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            sd_phv_valid = 1'b1;
            state_d      = S_ISSUE;
`ifdef DEPARSE_SCHED_EARLY_EXIT_EN
            if (!slot_w[0][0]) state_d = S_DRAIN;
`endif
         end
         S_ISSUE: begin
            if (issuable(cur)) begin
               sd_action       = cur[5:0];
               sd_action_valid = 1'b1;
               push            = 1'b1;
            end
            if (slot_q == CW'(C_NUM_ACTIONS - 1)) begin
               state_d = S_DRAIN;
            end else begin
               slot_d = slot_q + CW'(1);
`ifdef DEPARSE_SCHED_EARLY_EXIT_EN
               // Look one slot ahead so the first invalid slot's cycle is already a DRAIN cycle.
               if (!slot_w[slot_q + CW'(1)][0]) state_d = S_DRAIN;
`endif
            end
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pop = sd_valid && (cnt_q != 2'd0);

   always_comb begin
      exp_d = exp_q;
      cnt_d = cnt_q;
      if (pop) begin
         exp_d[0] = exp_q[1];
         exp_d[1] = '0;
         cnt_d    = cnt_q - 2'd1;
      end
      if (push) begin
         if (cnt_d == 2'd0) begin
            exp_d[0] = {cur[6 +: C_OFFSET_WIDTH], cur[5:4]};
            cnt_d    = 2'd1;
         end else if (cnt_d == 2'd1) begin
            exp_d[1] = {cur[6 +: C_OFFSET_WIDTH], cur[5:4]};
            cnt_d    = 2'd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         slot_q      <= '0;
         drain_q     <= 1'b0;
         phv_q       <= '0;
         actions_q   <= '0;
         exp_q       <= '{default: '0};
         cnt_q       <= 2'd0;
         wr_data_q   <= '0;
         wr_offset_q <= '0;
         wr_len_q    <= 2'b00;
         wr_valid_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         drain_q <= drain_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            phv_q     <= in_phv;
            actions_q <= in_actions;
         end
         wr_valid_q <= pop;
         if (pop) begin
            wr_data_q   <= mask_field(sd_data, head[1:0]);
            wr_offset_q <= head[2 +: C_OFFSET_WIDTH];
            wr_len_q    <= head[1:0];
         end
         // A type mismatch still writes using the issued type; only the error flag reports it.
         rsp_err_q <= sd_valid && ((cnt_q == 2'd0) || (sd_select != head[1:0]));
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign sd_phv    = phv_q;
   assign wr_data   = wr_data_q;
   assign wr_offset = wr_offset_q;
   assign wr_len    = wr_len_q;
   assign wr_valid  = wr_valid_q;
   assign rsp_err   = rsp_err_q;

endmodule
